// File: rtl/dec3_8_seq.sv
// dec3_8_seq: sequenced 3-to-8 binary-to-one-hot decoder.
// Codes are accepted over a valid/ready handshake and buffered in a small FIFO.
// Each code is then replayed as a one-hot pulse on y, held for PULSE_LEN cycles.
// Optional macro DEC_PARITY_EN adds in_par/par_err. When it is enabled, even
// parity is checked on every push, and entries with bad parity are dropped.
module dec3_8_seq #(
  parameter int DEPTH     = 4,  // FIFO entries, power of 2, >= 2
  parameter int PULSE_LEN = 3   // hold cycles per one-hot pulse, >= 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
`ifdef DEC_PARITY_EN
  input  logic       in_par,
  output logic       par_err,
`endif
  output logic [7:0] y,
  output logic       out_last,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    y_q, y_d;

  logic accept;  // handshake completes on this edge
  logic store;   // accepted code is actually written
  logic pop;     // head is consumed into y on this edge

  // in_ready depends only on registered count, so there is no push-through when full.
  assign in_ready = (count_q != (AW+1)'(DEPTH));
  assign accept   = in_valid && in_ready;

`ifdef DEC_PARITY_EN
  logic par_ok;
  logic par_err_q, par_err_d;
  assign par_ok    = ~^{in_par, in_code};
  assign store     = accept && par_ok;
  assign par_err_d = accept && !par_ok;
  assign par_err   = par_err_q;

  // One-cycle error pulse after an edge that rejects a bad-parity push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end
`else
  assign store = accept;
`endif

  // Pop when enabled and data is waiting, either from IDLE or on the last hold cycle.
  assign pop = en && (count_q != '0) && ((state_q == IDLE) || (cnt_q == '0));

  // FIFO pointer and occupancy next-state. Pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (store) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    case ({store, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage. Stale contents are harmless because the pointers are reset.
  always_ff @(posedge clk) begin
    if (store) mem_q[wr_ptr_q] <= in_code;
  end

  // Decoder FSM next-state. y changes only on a pop or when returning to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          y_d     = 8'b1 << mem_q[rd_ptr_q];
          cnt_d   = CW'(PULSE_LEN - 1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (pop) begin
          y_d   = 8'b1 << mem_q[rd_ptr_q];
          cnt_d = CW'(PULSE_LEN - 1);
        end else begin
          y_d     = 8'b0;
          state_d = IDLE;
        end
      end
      default: begin
        y_d     = 8'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, FIFO control and output registers. Reset clears y immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      y_q      <= 8'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
    end
  end

  assign y        = y_q;
  assign out_last = (state_q == HOLD) && (cnt_q == '0);
  assign busy     = (state_q == HOLD) || (count_q != '0);

endmodule

// File: tb/tb_dec3_8_seq.sv
// Bench for dec3_8_seq. It drives two instances from the same stimulus:
// instance 0 uses PULSE_LEN=3 and instance 1 uses PULSE_LEN=1. Each instance
// has its own queue/countdown reference model.
module tb_dec3_8_seq;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_par;
  logic       in_ready_a [2];
  logic [7:0] y_a        [2];
  logic       out_last_a [2];
  logic       busy_a     [2];
  logic       par_err_a  [2];

  always #5 clk = ~clk;

  dec3_8_seq #(.DEPTH(DEPTH), .PULSE_LEN(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
    .in_ready(in_ready_a[0]), .in_code(in_code),
`ifdef DEC_PARITY_EN
    .in_par(in_par), .par_err(par_err_a[0]),
`endif
    .y(y_a[0]), .out_last(out_last_a[0]), .busy(busy_a[0])
  );

  dec3_8_seq #(.DEPTH(DEPTH), .PULSE_LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
    .in_ready(in_ready_a[1]), .in_code(in_code),
`ifdef DEC_PARITY_EN
    .in_par(in_par), .par_err(par_err_a[1]),
`endif
    .y(y_a[1]), .out_last(out_last_a[1]), .busy(busy_a[1])
  );

`ifndef DEC_PARITY_EN
  initial begin
    par_err_a[0] = 1'b0;
    par_err_a[1] = 1'b0;
  end
`endif

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
    end
  endtask

  // Reference model: a plain circular queue plus "cycles of pulse remaining".
  int mq   [2][DEPTH];
  int mh   [2];
  int msz  [2];
  int mrem [2];
  int mcur [2];
  int mperr[2];

  function automatic int plen(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mh[i] = 0; msz[i] = 0; mrem[i] = 0; mcur[i] = 0; mperr[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit rdy, pok, do_pop, do_push;
        rdy = (msz[i] < DEPTH);
`ifdef DEC_PARITY_EN
        pok = ((in_par + in_code[0] + in_code[1] + in_code[2]) % 2) == 0;
`else
        pok = 1'b1;
`endif
        do_pop  = en && (msz[i] > 0) && (mrem[i] <= 1);
        do_push = in_valid && rdy && pok;
        mperr[i] = (in_valid && rdy && !pok) ? 1 : 0;
        if (do_pop) begin
          mcur[i] = mq[i][mh[i]];
          mh[i]   = (mh[i] + 1) % DEPTH;
          msz[i]  = msz[i] - 1;
          mrem[i] = plen(i);
        end else if (mrem[i] > 0) begin
          mrem[i] = mrem[i] - 1;
        end
        if (do_push) begin
          mq[i][(mh[i] + msz[i]) % DEPTH] = int'(in_code);
          msz[i] = msz[i] + 1;
        end
      end
    end
  end

  // Pulse log: one entry per completed pulse, holding its y value and length.
  logic [7:0] lg_y [2][64];
  int         lg_r [2][64];
  int         lg_n [2];
  int         run  [2];
  int         gap0;
  int         perr_cnt;

  // Per-cycle comparison of both instances against the model, plus logging.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [7:0] req_y;
      req_y = (mrem[i] > 0) ? (8'd1 << mcur[i]) : 8'd0;
      chk($sformatf("y[%0d]", i), int'(y_a[i]), int'(req_y));
      chk($sformatf("out_last[%0d]", i), int'(out_last_a[i]), (mrem[i] == 1) ? 1 : 0);
      chk($sformatf("busy[%0d]", i), int'(busy_a[i]), (mrem[i] > 0 || msz[i] > 0) ? 1 : 0);
      chk($sformatf("in_ready[%0d]", i), int'(in_ready_a[i]), (msz[i] < DEPTH) ? 1 : 0);
`ifdef DEC_PARITY_EN
      chk($sformatf("par_err[%0d]", i), int'(par_err_a[i]), mperr[i]);
`endif
      if (y_a[i] != 8'd0) begin
        run[i]++;
        if (out_last_a[i]) begin
          if (lg_n[i] < 64) begin
            lg_y[i][lg_n[i]] = y_a[i];
            lg_r[i][lg_n[i]] = run[i];
            lg_n[i]++;
          end
          run[i] = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
    if (y_a[0] == 8'd0 && busy_a[0]) gap0++;
    if (par_err_a[0]) perr_cnt++;
  end

  // Stimulus phase: inputs change 2 time units after each rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    lg_n[0] = 0; lg_n[1] = 0; gap0 = 0; perr_cnt = 0;
  endtask

  task automatic send(input logic [2:0] c, input logic bad);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_code  = c;
    in_par   = (^c) ^ bad;
    while (!in_ready_a[0] && t < 200) begin
      cyc(1);
      t++;
    end
    if (t >= 200) chk("send_timeout", 1, 0);
    cyc(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy_a[0] || busy_a[1]) && t < 500) begin
      cyc(1);
      t++;
    end
    if (t >= 500) chk("idle_timeout", 1, 0);
    cyc(1);
  endtask

  logic [7:0] tbl   [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [2:0] burst [5] = '{3'd5, 3'd2, 3'd7, 3'd0, 3'd3};
  logic [7:0] bexp  [5] = '{8'h20, 8'h04, 8'h80, 8'h01, 8'h08};
  logic [2:0] p1    [3] = '{3'd1, 3'd1, 3'd4};
  logic [7:0] p1exp [3] = '{8'h02, 8'h02, 8'h10};

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_code = 3'd0; in_par = 1'b0;
    run[0] = 0; run[1] = 0;
    clear_logs();
    cyc(3);
    chk("reset_y", int'(y_a[0]), 0);
    chk("reset_in_ready", int'(in_ready_a[0]), 1);
    chk("reset_busy", int'(busy_a[0]), 0);
    chk("reset_out_last", int'(out_last_a[0]), 0);
    rst_n = 1'b1;
    cyc(2);

    // Single codes 0..7, each a clean 3-cycle pulse.
    for (int k = 0; k < 8; k++) begin
      clear_logs();
      send(3'(k), 1'b0);
      wait_idle();
      chk($sformatf("single%0d_n", k), lg_n[0], 1);
      chk($sformatf("single%0d_y", k), int'(lg_y[0][0]), int'(tbl[k]));
      chk($sformatf("single%0d_len", k), lg_r[0][0], 3);
      $display("single code %0d -> y=%02h len=%0d", k, lg_y[0][0], lg_r[0][0]);
    end

    // Burst of five with in_valid held high: back-to-back pulses, in order.
    clear_logs();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int t;
      t = 0;
      in_code = burst[i];
      in_par  = ^burst[i];
      while (!in_ready_a[0] && t < 200) begin
        cyc(1);
        t++;
      end
      cyc(1);
    end
    in_valid = 1'b0;
    wait_idle();
    chk("burst_n", lg_n[0], 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("burst%0d_y", i), int'(lg_y[0][i]), int'(bexp[i]));
      chk($sformatf("burst%0d_len", i), lg_r[0][i], 3);
    end
    chk("burst_gap", gap0, 1);
    $display("burst: %0d pulses, idle-busy cycles=%0d", lg_n[0], gap0);

    // en low with two codes queued; en dropped mid-pulse does not truncate it.
    clear_logs();
    en = 1'b0;
    send(3'd3, 1'b0);
    send(3'd6, 1'b0);
    cyc(4);
    chk("en0_y", int'(y_a[0]), 0);
    chk("en0_busy", int'(busy_a[0]), 1);
    en = 1'b1;
    cyc(1);
    chk("en1_first_y", int'(y_a[0]), 8'h08);
    cyc(1);
    en = 1'b0;
    cyc(5);
    chk("en_drop_n", lg_n[0], 1);
    chk("en_drop_len", lg_r[0][0], 3);
    chk("en_drop_y", int'(y_a[0]), 0);
    chk("en_drop_busy", int'(busy_a[0]), 1);
    en = 1'b1;
    wait_idle();
    chk("en_resume_n", lg_n[0], 2);
    chk("en_resume_y", int'(lg_y[0][1]), 8'h40);
    $display("en gating: pulses=%0d", lg_n[0]);

    // Asynchronous reset in the middle of holding code 6.
    clear_logs();
    send(3'd6, 1'b0);
    send(3'd2, 1'b0);
    chk("prereset_y", int'(y_a[0]), 8'h40);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_y", int'(y_a[0]), 0);
    chk("midreset_in_ready", int'(in_ready_a[0]), 1);
    chk("midreset_busy", int'(busy_a[0]), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(10);
    chk("postreset_n", lg_n[0], 0);
    chk("postreset_y", int'(y_a[0]), 0);
    $display("mid-hold reset: y=%02h busy=%0d", y_a[0], busy_a[0]);

    // PULSE_LEN=1 instance: consecutive single-cycle pulses.
    clear_logs();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_code = p1[i];
      in_par  = ^p1[i];
      cyc(1);
    end
    in_valid = 1'b0;
    wait_idle();
    chk("p1_n", lg_n[1], 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("p1_%0d_y", i), int'(lg_y[1][i]), int'(p1exp[i]));
      chk($sformatf("p1_%0d_len", i), lg_r[1][i], 1);
    end
    $display("pulse_len=1: pulses=%0d", lg_n[1]);

`ifdef DEC_PARITY_EN
    // A bad-parity push is rejected with a one-cycle error; a good push decodes.
    clear_logs();
    send(3'd3, 1'b1);
    cyc(3);
    chk("par_bad_err", perr_cnt, 1);
    chk("par_bad_n", lg_n[0], 0);
    send(3'd3, 1'b0);
    wait_idle();
    chk("par_good_n", lg_n[0], 1);
    chk("par_good_y", int'(lg_y[0][0]), 8'h08);
    chk("par_good_err", perr_cnt, 1);
    $display("parity: errors=%0d pulses=%0d", perr_cnt, lg_n[0]);
`endif

    // Random traffic checked each cycle by the model.
    for (int n = 0; n < 400; n++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_code  = 3'($urandom);
      en       = ($urandom_range(0, 3) != 0);
      in_par   = (^in_code) ^ ($urandom_range(0, 7) == 0);
      cyc(1);
    end
    in_valid = 1'b0;
    en = 1'b1;
    wait_idle();
    $display("random phase done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
